// File: rtl/cnn_pkg.sv
// Shared constants and types for the single-layer 1-D convolution engine.
package cnn_pkg;
    localparam int DATA_W  = 4;
    localparam int TAPS    = 3;
    localparam int NUM_WIN = 5;
    localparam int DEPTH   = TAPS * NUM_WIN;
    localparam int PROD_W  = 2 * DATA_W;
    localparam int RES_W   = PROD_W + 2;
    localparam int ADDR_W  = 4;
    localparam int RPTR_W  = 3;

    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [RES_W-1:0]  res_t;
endpackage

// File: rtl/cnn_reg_file.sv
// Product storage: DEPTH x PROD_W, one synchronous write port, three asynchronous read ports.
module cnn_reg_file
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [PROD_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr0_i,
    input  logic [ADDR_W-1:0] rd_addr1_i,
    input  logic [ADDR_W-1:0] rd_addr2_i,
    output logic [PROD_W-1:0] rd_data0_o,
    output logic [PROD_W-1:0] rd_data1_o,
    output logic [PROD_W-1:0] rd_data2_o
);
    prod_t mem_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i && (wr_addr_i < ADDR_W'(DEPTH))) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Addresses beyond the array read as zero rather than indexing out of range.
    assign rd_data0_o = (rd_addr0_i < ADDR_W'(DEPTH)) ? mem_q[rd_addr0_i] : '0;
    assign rd_data1_o = (rd_addr1_i < ADDR_W'(DEPTH)) ? mem_q[rd_addr1_i] : '0;
    assign rd_data2_o = (rd_addr2_i < ADDR_W'(DEPTH)) ? mem_q[rd_addr2_i] : '0;
endmodule

// File: rtl/cnn_single_layer_1d.sv
// 1-D convolution engine: stores Image*Filter products while Start is high,
// then emits one 3-tap window sum per ReadEn clock.
module cnn_single_layer_1d
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic [DATA_W-1:0] Image,
    input  logic [DATA_W-1:0] Filter,
    input  logic              ReadEn,
    output logic [RES_W-1:0]  ConvResult
);
    logic              start_q;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [RPTR_W-1:0] rptr_q, rptr_d;
    res_t              conv_q, conv_d;
    logic              start_rise;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    prod_t             prod;
    logic [ADDR_W-1:0] rd_addr0, rd_addr1, rd_addr2;
    prod_t             rd_data0, rd_data1, rd_data2;
    res_t              win_sum;

    assign start_rise = Start && !start_q;
    assign prod       = PROD_W'(Image) * PROD_W'(Filter);

    // Window base address 3*rptr built as 2*rptr + rptr.
    assign rd_addr0 = {rptr_q, 1'b0} + {1'b0, rptr_q};
    assign rd_addr1 = rd_addr0 + ADDR_W'(1);
    assign rd_addr2 = rd_addr0 + ADDR_W'(2);
    assign win_sum  = RES_W'(rd_data0) + RES_W'(rd_data1) + RES_W'(rd_data2);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        conv_d  = conv_q;
        wr_en   = 1'b0;
        wr_addr = wptr_q;
        if (start_rise) begin
            wr_en   = 1'b1;
            wr_addr = '0;
            wptr_d  = ADDR_W'(1);
            rptr_d  = '0;
        end else if (Start) begin
            if (wptr_q < ADDR_W'(DEPTH)) begin
                wr_en  = 1'b1;
                wptr_d = wptr_q + ADDR_W'(1);
            end
        end else if (ReadEn && (rptr_q < RPTR_W'(NUM_WIN))) begin
            conv_d = win_sum;
            rptr_d = rptr_q + RPTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            conv_q  <= '0;
        end else begin
            start_q <= Start;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            conv_q  <= conv_d;
        end
    end

    assign ConvResult = conv_q;

    cnn_reg_file u_reg_file (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (prod),
        .rd_addr0_i (rd_addr0),
        .rd_addr1_i (rd_addr1),
        .rd_addr2_i (rd_addr2),
        .rd_data0_o (rd_data0),
        .rd_data1_o (rd_data1),
        .rd_data2_o (rd_data2)
    );
endmodule

// File: tb/tb_cnn_single_layer_1d.sv
// Directed bench for cnn_single_layer_1d: vector table for the nominal frame,
// hand-written sequences for saturation, priority, restart and reset corners.
module tb_cnn_single_layer_1d;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       Start = 1'b0;
    logic       ReadEn = 1'b0;
    logic [3:0] Image = '0;
    logic [3:0] Filter = '0;
    logic [9:0] ConvResult;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cnn_single_layer_1d dut (
        .clk        (clk),
        .reset      (reset),
        .Start      (Start),
        .Image      (Image),
        .Filter     (Filter),
        .ReadEn     (ReadEn),
        .ConvResult (ConvResult)
    );

    typedef struct {
        logic       st;
        logic [3:0] im;
        logic [3:0] fl;
        logic       rd;
        logic [9:0] exp;
    } vec_t;

    vec_t nom [22];
    int   nom_res [7] = '{14, 20, 26, 32, 38, 38, 38};

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [3:0] im, input logic [3:0] fl, input logic rd);
        Start  = st;
        Image  = im;
        Filter = fl;
        ReadEn = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset asserted between clock edges
        #2 reset = 1'b1;
        #2 chk("reset_async", ConvResult, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // nominal frame table
        for (int k = 0; k < 15; k++)
            nom[k] = '{1'b1, 4'(k / 3 + k % 3 + 1), 4'(k % 3 + 1), 1'b0, 10'd0};
        for (int r = 0; r < 7; r++)
            nom[15 + r] = '{1'b0, 4'd0, 4'd0, 1'b1, 10'(nom_res[r])};
        for (int i = 0; i < 22; i++) begin
            drive(nom[i].st, nom[i].im, nom[i].fl, nom[i].rd);
            chk($sformatf("nominal[%0d]", i), ConvResult, nom[i].exp);
        end

        // maximum operands
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        for (int k = 0; k < 15; k++) drive(1'b1, 4'd15, 4'd15, 1'b0);
        for (int r = 0; r < 6; r++) begin
            drive(1'b0, 4'd0, 4'd0, 1'b1);
            chk($sformatf("max[%0d]", r), ConvResult, 675);
        end

        // 17 writes: the last two must be dropped
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        for (int k = 0; k < 17; k++) begin
            if (k < 15) drive(1'b1, 4'(k + 1), 4'd1, 1'b0);
            else        drive(1'b1, 4'd15, 4'd15, 1'b0);
        end
        for (int r = 0; r < 6; r++) begin
            drive(1'b0, 4'd0, 4'd0, 1'b1);
            chk($sformatf("wr_sat[%0d]", r), ConvResult, (r < 5) ? 9 * r + 6 : 42);
        end

        // restart with ReadEn asserted during some write cycles
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        for (int k = 0; k < 15; k++) begin
            drive(1'b1, 4'd3, 4'(k / 3 + 1), (k % 5 == 4));
            chk($sformatf("prio_hold[%0d]", k), ConvResult, 42);
        end
        for (int r = 0; r < 6; r++) begin
            drive(1'b0, 4'd0, 4'd0, 1'b1);
            chk($sformatf("restart[%0d]", r), ConvResult, (r < 5) ? 9 * (r + 1) : 45);
        end

        // reset in the middle of the read phase
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        for (int k = 0; k < 15; k++) drive(1'b1, 4'd1, 4'd1, 1'b0);
        for (int r = 0; r < 2; r++) begin
            drive(1'b0, 4'd0, 4'd0, 1'b1);
            chk($sformatf("pre_reset[%0d]", r), ConvResult, 3);
        end
        reset = 1'b1;
        #2 chk("mid_reset", ConvResult, 0);
        reset = 1'b0;
        for (int r = 0; r < 5; r++) begin
            drive(1'b0, 4'd0, 4'd0, 1'b1);
            chk($sformatf("empty_read[%0d]", r), ConvResult, 0);
        end

        // read a partially written frame
        for (int k = 0; k < 4; k++) drive(1'b1, 4'd2, 4'd2, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        chk("partial[0]", ConvResult, 12);
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        chk("partial[1]", ConvResult, 4);
        drive(1'b0, 4'd0, 4'd0, 1'b1);
        chk("partial[2]", ConvResult, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
